chan_mode_ctrl: RTL

//  Parametrised N-channel start/done job controller; next generation of the mode_t blocks.

---
 rtl/mode_pkg.sv | 4 +
 rtl/chan_mode_ctrl_if.sv | 15 +
 rtl/chan_mode_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mode_pkg.sv
// Per-channel job state type shared by chan_mode_ctrl and its clients.
package mode_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} mode_t;
endpackage

// File: rtl/chan_mode_ctrl_if.sv
// Completion-report valid/ready port of chan_mode_ctrl (master = controller, slave = consumer).
interface chan_mode_ctrl_if #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CNTW = 8
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            rpt_valid;
    logic            rpt_ready;
    logic [CHW-1:0]  rpt_ch;
    logic [CNTW-1:0] rpt_len;

    modport master (output rpt_valid, output rpt_ch, output rpt_len, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_ch, input rpt_len, output rpt_ready);
endinterface

// File: rtl/chan_mode_ctrl.sv
// N-channel start/done job controller with a round-robin completion report port.
// Optional feature: define CHAN_ABORT_EN to add the per-channel abort input.
module chan_mode_ctrl
    import mode_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      start,
    input  logic [NCH*CNTW-1:0] len,
`ifdef CHAN_ABORT_EN
    input  logic [NCH-1:0]      abort,
`endif
    output mode_t [NCH-1:0]     mode_o,
    output logic                busy_o,
    chan_mode_ctrl_if.master    rpt
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    mode_t [NCH-1:0] mode_q;
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] len_q [NCH];
    logic [NCH-1:0]  loaded_q;
    logic [CHW-1:0]  rr_q;
    logic            rpt_valid_q;
    logic [CHW-1:0]  rpt_ch_q;
    logic [CNTW-1:0] rpt_len_q;

    logic            hs;
    logic            load;
    logic [NCH-1:0]  cand;
    logic [NCH-1:0]  run_vec;
    logic            gnt_vld;
    logic [CHW-1:0]  gnt_ch;
    logic [CHW-1:0]  idx;

    // A channel already sitting in the report register is excluded via loaded_q,
    // so the channel being handshaken this cycle can never be granted again.
    always_comb begin
        hs      = rpt_valid_q & rpt.rpt_ready;
        load    = ~rpt_valid_q | hs;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand[i]    = (mode_q[i] == DONE) & ~loaded_q[i];
            run_vec[i] = (mode_q[i] == RUN);
        end
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = CHW'((32'(rr_q) + k) % NCH);
            if (!gnt_vld && cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                mode_q[i] <= IDLE;
                cnt_q[i]  <= '0;
                len_q[i]  <= '0;
            end
            loaded_q    <= '0;
            rr_q        <= '0;
            rpt_valid_q <= 1'b0;
            rpt_ch_q    <= '0;
            rpt_len_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                case (mode_q[i])
                    IDLE: begin
                        if (start[i]) begin
                            len_q[i] <= len[i*CNTW +: CNTW];
                            if (len[i*CNTW +: CNTW] != '0) begin
                                mode_q[i] <= RUN;
                                cnt_q[i]  <= len[i*CNTW +: CNTW];
                            end else begin
                                mode_q[i] <= DONE;
                            end
                        end
                    end
                    RUN: begin
`ifdef CHAN_ABORT_EN
                        if (abort[i]) begin
                            mode_q[i] <= IDLE;
                            cnt_q[i]  <= '0;
                        end else
`endif
                        if (cnt_q[i] == CNTW'(1)) begin
                            mode_q[i] <= DONE;
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] - CNTW'(1);
                        end
                    end
                    DONE: begin
                        if (hs && rpt_ch_q == CHW'(i)) begin
                            mode_q[i] <= IDLE;
                        end
                    end
                    default: begin
                        mode_q[i] <= IDLE;
                        cnt_q[i]  <= '0;
                    end
                endcase

                if (hs && rpt_ch_q == CHW'(i)) begin
                    loaded_q[i] <= 1'b0;
                end else if (load && gnt_vld && gnt_ch == CHW'(i)) begin
                    loaded_q[i] <= 1'b1;
                end
            end

            if (load) begin
                rpt_valid_q <= gnt_vld;
                if (gnt_vld) begin
                    rpt_ch_q  <= gnt_ch;
                    rpt_len_q <= len_q[gnt_ch];
                    rr_q      <= gnt_ch;
                end
            end
        end
    end

    assign mode_o        = mode_q;
    assign busy_o        = |run_vec;
    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_ch    = rpt_ch_q;
    assign rpt.rpt_len   = rpt_len_q;
endmodule
